merge_pass_sched: RTL and testbench
===================================

# merge_pass_sched

Schedules the multi-pass ping/pong merge sort that follows the `sort_16` stage. After the input stream has been loaded, `sort_16` leaves sorted runs of `BASE_RUN` pairs in `mem_ping`. This block then issues one merge job at a time to the merge engine, doubling the run length each pass and swapping the source and destination memory, until a single sorted run remains. It reports which memory holds the result, and it owns no datapath beyond counters and address arithmetic.

## Interface
Parameters:
- `ADDR_W`, default `` `BANK_ADDR_WIDTH ``+1: pair-address width across both banks.
- `BASE_RUN`, default 16: length of the presorted runs; power of two, ≥2.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `start_in`  in  1  one-cycle pulse when loading and sort_16 are complete.
- `count_in`  in  ADDR_W+1  total pairs loaded; sampled only on an accepted start.
- `job_valid_out`  out  1  job offer to the merge engine.
- `job_ready_in`  in  1  merge engine accepts the job.
- `job_left_base_out`  out  ADDR_W  base address of the left run in the source memory.
- `job_left_len_out`  out  ADDR_W+1  left run length.
- `job_right_base_out`  out  ADDR_W  base address of the right run.
- `job_right_len_out`  out  ADDR_W+1  right run length; 0 means a copy-only tail.
- `job_dst_base_out`  out  ADDR_W  base address in the destination memory; always equals the left base.
- `job_done_in`  in  1  one-cycle pulse: the accepted job has been fully written back.
- `src_is_pong_out`  out  1  current pass reads `mem_pong` and writes `mem_ping`.
- `busy_out`  out  1  scheduler is active.
- `done_out`  out  1  one-cycle completion pulse.
- `result_in_pong_out`  out  1  the final sorted data is in `mem_pong`; valid from `done_out` until the next accepted start.

## Operation
- States:
  - `IDLE`: waits for a start.
  - `ISSUE`: offers a job.
  - `WAIT`: waits for the job to complete.
  - `NEXT_PASS`: swaps memories and doubles the run length.
  - `FINISH`: signals completion.
- Internal registers:
  - `cnt` (ADDR_W+1 bits): the sampled `count_in`.
  - `L` (ADDR_W+2 bits, cannot overflow): current run length.
  - `base` (ADDR_W+2 bits): base of the current job.
- `IDLE` with `start_in`:
  - Load `cnt`, set `L`=BASE_RUN, `base`=0, `src_is_pong_out`=0, `busy_out`=1.
  - If `cnt` ≤ BASE_RUN (including 0), go to `FINISH`; otherwise go to `ISSUE`.
- Job fields while in `ISSUE`:
  - left base = `base`; left length = min(L, `cnt`−`base`).
  - right base = `base`+L; right length = `cnt` > `base`+L ? min(L, `cnt`−`base`−L) : 0.
  - destination base = `base`.
- `ISSUE`: `job_valid_out`=1 with all fields held stable. On `job_ready_in` go to `WAIT`.
- `WAIT` on `job_done_in`:
  - `base` += 2L.
  - If the new `base` < `cnt`, go to `ISSUE`; otherwise go to `NEXT_PASS`.
- `NEXT_PASS`:
  - Toggle `src_is_pong_out`, double `L`, set `base`=0.
  - If the doubled `L` ≥ `cnt`, go to `FINISH`; otherwise go to `ISSUE`.
- `FINISH`:
  - `done_out`=1 for one cycle.
  - `result_in_pong_out` = `src_is_pong_out`, which has already been toggled and so names the last destination.
  - Go to `IDLE` with `busy_out`=0.
- Ignored inputs:
  - `start_in` while `busy_out` is high.
  - `job_done_in` outside `WAIT`.
  - `job_ready_in` outside `ISSUE`.
- At most one job is outstanding at any time.
- All bases are multiples of BASE_RUN, so they are even and every job starts on the even bank.

## Timing
- Reset values:
  - All outputs are 0; state is `IDLE`.
  - A reset in any state aborts the operation the next cycle; no `done_out` is produced.
- Start to first job: `start_in` at cycle t gives `job_valid_out` at t+1.
- `count_in` ≤ BASE_RUN: `done_out` at t+1, `result_in_pong_out`=0.
- Job acceptance: accepted on the cycle with valid & ready; `job_valid_out` drops the following cycle.
- Job to job: `job_done_in` at cycle d gives the next `job_valid_out` at d+1 within a pass, or at d+2 across a pass boundary.
- Final job: `job_done_in` on the final job at cycle d gives `done_out` at d+2.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `MERGE_SCHED_STATS_EN` defined:
  - Adds output `stat_passes_out` (8 bits), the number of completed passes.
  - Adds output `stat_cycles_out` (32 bits), the number of cycles from the accepted start to `done_out`.
  - Both are cleared on start and on reset, and hold their values after `done_out`.
- `MERGE_SCHED_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- count=16, start:
  - `done_out` one cycle later, no jobs issued, `result_in_pong_out`=0.
- count=64:
  - Pass 0 (`src_is_pong_out`=0): jobs (L0,16 | R16,16 | D0) and (L32,16 | R48,16 | D32).
  - Pass 1 (`src_is_pong_out`=1): job (L0,32 | R32,32 | D0).
  - Completion: `done_out` with `result_in_pong_out`=0.
- count=40:
  - Pass 0: jobs (0,16 | 16,16) and (32,8 | 40,0).
  - Pass 1: job (0,32 | 32,8).
  - Completion: `done_out`, result in ping.
- Backpressure: hold `job_ready_in`=0 for 5 cycles -> `job_valid_out` and every job field stay constant; exactly one job is accepted.
- Ignored inputs:
  - `start_in` pulsed during `WAIT` -> ignored; the job sequence is unchanged.
  - Spurious `job_done_in` in `ISSUE` -> ignored.
- Reset in `WAIT` during the count=64 run:
  - All outputs are 0 the next cycle.
  - A new start with count=32 then yields the single job (0,16 | 16,16) and a pong result.

Source files
------------

// File: rtl/merge_pass_sched_if.sv
// Merge-job bus between merge_pass_sched (master) and the merge engine (slave).
// Width follows BANK_ADDR_WIDTH when ADDR_W is not overridden.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 9
`endif

interface merge_pass_sched_if #(
  parameter int unsigned ADDR_W = `BANK_ADDR_WIDTH + 1
);
  logic              job_valid_out;
  logic              job_ready_in;
  logic [ADDR_W-1:0] job_left_base_out;
  logic [ADDR_W:0]   job_left_len_out;
  logic [ADDR_W-1:0] job_right_base_out;
  logic [ADDR_W:0]   job_right_len_out;
  logic [ADDR_W-1:0] job_dst_base_out;
  logic              job_done_in;

  modport master (
    output job_valid_out, job_left_base_out, job_left_len_out,
           job_right_base_out, job_right_len_out, job_dst_base_out,
    input  job_ready_in, job_done_in
  );

  modport slave (
    input  job_valid_out, job_left_base_out, job_left_len_out,
           job_right_base_out, job_right_len_out, job_dst_base_out,
    output job_ready_in, job_done_in
  );
endinterface

// File: rtl/merge_pass_sched.sv
// merge_pass_sched: schedules ping/pong merge passes after sort_16.
// Issues one merge job at a time, doubling the run length each pass and
// swapping source/destination memory until a single sorted run remains.
// Optional feature macro: MERGE_SCHED_STATS_EN adds pass/cycle statistics.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 9
`endif

module merge_pass_sched #(
  parameter int unsigned ADDR_W   = `BANK_ADDR_WIDTH + 1,
  parameter int unsigned BASE_RUN = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_in,
  input  logic [ADDR_W:0]     count_in,
  merge_pass_sched_if.master  job,
  output logic                src_is_pong_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                result_in_pong_out
`ifdef MERGE_SCHED_STATS_EN
  ,
  output logic [7:0]          stat_passes_out,
  output logic [31:0]         stat_cycles_out
`endif
);

  localparam int unsigned LW = ADDR_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT_PASS,
    S_FINISH
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] lbase;
    logic [ADDR_W:0]   llen;
    logic [ADDR_W-1:0] rbase;
    logic [ADDR_W:0]   rlen;
  } job_t;

  state_e          state_q;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   base_q, base_d;
  logic            src_q, busy_q, done_q, result_q, valid_q;
  job_t            job_q, job_d;

  logic [LW-1:0]   cnt_ext, rem_l, rbase_full, rem_r;

`ifdef MERGE_SCHED_STATS_EN
  logic [7:0]      passes_q;
  logic [31:0]     cycles_q;
`endif

  // Next counter/address values, and the job those values would describe.
  // Fields are built from the next-state values so they can be registered
  // on the same edge that enters ISSUE.
  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    base_d = base_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          cnt_d  = count_in;
          len_d  = LW'(BASE_RUN);
          base_d = '0;
        end
      end
      S_WAIT: begin
        if (job.job_done_in) begin
          base_d = base_q + (len_q << 1);
        end
      end
      S_NEXT_PASS: begin
        len_d  = len_q << 1;
        base_d = '0;
      end
      default: ;
    endcase

    cnt_ext    = {1'b0, cnt_d};
    rem_l      = cnt_ext - base_d;
    rbase_full = base_d + len_d;
    rem_r      = cnt_ext - rbase_full;

    job_d.lbase = base_d[ADDR_W-1:0];
    job_d.llen  = (ADDR_W+1)'((len_d < rem_l) ? len_d : rem_l);
    job_d.rbase = rbase_full[ADDR_W-1:0];
    job_d.rlen  = (cnt_ext > rbase_full)
                  ? (ADDR_W+1)'((len_d < rem_r) ? len_d : rem_r)
                  : '0;
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      base_q   <= '0;
      src_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      valid_q  <= 1'b0;
      job_q    <= '0;
`ifdef MERGE_SCHED_STATS_EN
      passes_q <= '0;
      cycles_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            base_q <= base_d;
            src_q  <= 1'b0;
            busy_q <= 1'b1;
`ifdef MERGE_SCHED_STATS_EN
            passes_q <= '0;
            cycles_q <= 32'd1;
`endif
            if (cnt_ext <= LW'(BASE_RUN)) begin
              done_q   <= 1'b1;
              result_q <= 1'b0;
              state_q  <= S_FINISH;
            end else begin
              valid_q <= 1'b1;
              job_q   <= job_d;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (job.job_ready_in) begin
            valid_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (job.job_done_in) begin
            base_q <= base_d;
            if (base_d < cnt_ext) begin
              valid_q <= 1'b1;
              job_q   <= job_d;
              state_q <= S_ISSUE;
            end else begin
              state_q <= S_NEXT_PASS;
            end
          end
        end
        S_NEXT_PASS: begin
          src_q  <= ~src_q;
          len_q  <= len_d;
          base_q <= base_d;
`ifdef MERGE_SCHED_STATS_EN
          passes_q <= passes_q + 8'd1;
`endif
          // done_out is raised on entry to FINISH so it lands two cycles
          // after the final job_done_in.
          if (len_d >= cnt_ext) begin
            done_q   <= 1'b1;
            result_q <= ~src_q;
            state_q  <= S_FINISH;
          end else begin
            valid_q <= 1'b1;
            job_q   <= job_d;
            state_q <= S_ISSUE;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef MERGE_SCHED_STATS_EN
      if (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_NEXT_PASS) begin
        cycles_q <= cycles_q + 32'd1;
      end
`endif
    end
  end

  assign job.job_valid_out      = valid_q;
  assign job.job_left_base_out  = job_q.lbase;
  assign job.job_left_len_out   = job_q.llen;
  assign job.job_right_base_out = job_q.rbase;
  assign job.job_right_len_out  = job_q.rlen;
  assign job.job_dst_base_out   = job_q.lbase;

  assign src_is_pong_out    = src_q;
  assign busy_out           = busy_q;
  assign done_out           = done_q;
  assign result_in_pong_out = result_q;

`ifdef MERGE_SCHED_STATS_EN
  assign stat_passes_out = passes_q;
  assign stat_cycles_out = cycles_q;
`endif

endmodule

// File: tb/tb_merge_pass_sched.sv
// Directed testbench for merge_pass_sched (default build, stats disabled).
module tb_merge_pass_sched;

  localparam int AW = 10;
  localparam int JW = 5 * AW + 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_in = 1'b0;
  logic [AW:0]   count_in = '0;
  logic          src_is_pong, busy, done, result_pong;

  int vecs = 0;
  int errs = 0;

  merge_pass_sched_if #(.ADDR_W(AW)) jb ();

  merge_pass_sched #(.ADDR_W(AW), .BASE_RUN(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .start_in           (start_in),
    .count_in           (count_in),
    .job                (jb),
    .src_is_pong_out    (src_is_pong),
    .busy_out           (busy),
    .done_out           (done),
    .result_in_pong_out (result_pong)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Packs an expected job as {lbase, llen, rbase, rlen, dbase, src_is_pong}.
  function automatic logic [JW-1:0] jobv(int lb, int ll, int rb, int rl, int db, int sp);
    return {AW'(lb), (AW+1)'(ll), AW'(rb), (AW+1)'(rl), AW'(db), sp[0]};
  endfunction

  function automatic logic [JW-1:0] cur_job();
    return {jb.job_left_base_out, jb.job_left_len_out, jb.job_right_base_out,
            jb.job_right_len_out, jb.job_dst_base_out, src_is_pong};
  endfunction

  // Plays the merge engine for one job: waits for an offer, accepts it,
  // and pulses job_done_in a few cycles later. Returns just after the
  // edge that sampled job_done_in.
  task automatic serve_job(output bit got, output int waits,
                           output logic [JW-1:0] jp, output logic vdrop);
    got = 1'b0; waits = 0; jp = '0; vdrop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (jb.job_valid_out === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
      waits++;
    end
    if (!got) return;
    jp = cur_job();
    jb.job_ready_in = 1'b1;
    tick();
    jb.job_ready_in = 1'b0;
    vdrop = (jb.job_valid_out === 1'b0);
    tick();
    tick();
    jb.job_done_in = 1'b1;
    tick();
    jb.job_done_in = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    vecs++;
    if ({jb.job_valid_out, busy, done, src_is_pong, result_pong} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 00000",
               {jb.job_valid_out, busy, done, src_is_pong, result_pong});
    end
    vecs++;
    if (cur_job() !== '0) begin
      errs++;
      $display("FAIL reset_fields got %h want 0", cur_job());
    end
    reset = 1'b0;
    tick();
    vecs++;
    if ({busy, done} !== 2'b00) begin
      errs++;
      $display("FAIL reset_idle got %b want 00", {busy, done});
    end
  endtask

  task automatic test_short;
    logic [AW:0] cnts [2];
    cnts[0] = 11'd16;
    cnts[1] = 11'd0;
    for (int k = 0; k < 2; k++) begin
      count_in = cnts[k];
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      vecs++;
      if ({done, jb.job_valid_out, result_pong} !== 3'b100) begin
        errs++;
        $display("FAIL short_done cnt=%0d got %b want 100", cnts[k],
                 {done, jb.job_valid_out, result_pong});
      end
      tick();
      vecs++;
      if ({done, busy, jb.job_valid_out} !== 3'b000) begin
        errs++;
        $display("FAIL short_after cnt=%0d got %b want 000", cnts[k],
                 {done, busy, jb.job_valid_out});
      end
    end
  endtask

  task automatic test_count64;
    bit got; int w; logic [JW-1:0] jp; logic vd;
    logic [JW-1:0] exp [3];
    int expw [3];
    exp[0] = jobv(0, 16, 16, 16, 0, 0);  expw[0] = 0;
    exp[1] = jobv(32, 16, 48, 16, 32, 0); expw[1] = 0;
    exp[2] = jobv(0, 32, 32, 32, 0, 1);  expw[2] = 1;
    count_in = 11'd64;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    vecs++;
    if (jb.job_valid_out !== 1'b1) begin
      errs++;
      $display("FAIL c64_first_valid got %b want 1", jb.job_valid_out);
    end
    for (int j = 0; j < 3; j++) begin
      serve_job(got, w, jp, vd);
      vecs++;
      if ({got, vd} !== 2'b11) begin
        errs++;
        $display("FAIL c64_handshake job%0d got %b want 11", j, {got, vd});
      end
      vecs++;
      if (jp !== exp[j]) begin
        errs++;
        $display("FAIL c64_job%0d got %h want %h", j, jp, exp[j]);
      end
      vecs++;
      if (w !== expw[j]) begin
        errs++;
        $display("FAIL c64_latency job%0d got %0d want %0d", j, w, expw[j]);
      end
    end
    vecs++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL c64_done_early got %b want 0", done);
    end
    tick();
    vecs++;
    if ({done, result_pong} !== 2'b10) begin
      errs++;
      $display("FAIL c64_done got %b want 10", {done, result_pong});
    end
    tick();
  endtask

  task automatic test_count40;
    bit got; int w; logic [JW-1:0] jp, msk; logic vd;
    msk = '1;
    msk[3*AW+1:2*AW+2] = '0;
    count_in = 11'd40;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    serve_job(got, w, jp, vd);
    vecs++;
    if (!got || jp !== jobv(0, 16, 16, 16, 0, 0)) begin
      errs++;
      $display("FAIL c40_job0 got %h want %h", jp, jobv(0, 16, 16, 16, 0, 0));
    end
    serve_job(got, w, jp, vd);
    vecs++;
    if (!got || (jp & msk) !== (jobv(32, 8, 0, 0, 32, 0) & msk)) begin
      errs++;
      $display("FAIL c40_tail got %h want %h", jp & msk, jobv(32, 8, 0, 0, 32, 0) & msk);
    end
    serve_job(got, w, jp, vd);
    vecs++;
    if (!got || jp !== jobv(0, 32, 32, 8, 0, 1) || w !== 1) begin
      errs++;
      $display("FAIL c40_pass1 got %h wait %0d want %h wait 1", jp, w, jobv(0, 32, 32, 8, 0, 1));
    end
    tick();
    vecs++;
    if ({done, result_pong} !== 2'b10) begin
      errs++;
      $display("FAIL c40_done got %b want 10", {done, result_pong});
    end
    tick();
  endtask

  task automatic test_ignored;
    bit got; int w; logic [JW-1:0] jp; logic vd;
    count_in = 11'd64;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    jb.job_done_in = 1'b1;
    tick();
    jb.job_done_in = 1'b0;
    vecs++;
    if (jb.job_valid_out !== 1'b1 || cur_job() !== jobv(0, 16, 16, 16, 0, 0)) begin
      errs++;
      $display("FAIL ign_spurious_done got v=%b %h want v=1 %h", jb.job_valid_out,
               cur_job(), jobv(0, 16, 16, 16, 0, 0));
    end
    jb.job_ready_in = 1'b1;
    tick();
    jb.job_ready_in = 1'b0;
    count_in = 11'd16;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    count_in = 11'd64;
    vecs++;
    if ({busy, done, jb.job_valid_out} !== 3'b100) begin
      errs++;
      $display("FAIL ign_start_in_wait got %b want 100", {busy, done, jb.job_valid_out});
    end
    jb.job_done_in = 1'b1;
    tick();
    jb.job_done_in = 1'b0;
    serve_job(got, w, jp, vd);
    vecs++;
    if (!got || w !== 0 || jp !== jobv(32, 16, 48, 16, 32, 0)) begin
      errs++;
      $display("FAIL ign_job1 got %h wait %0d want %h wait 0", jp, w, jobv(32, 16, 48, 16, 32, 0));
    end
    serve_job(got, w, jp, vd);
    vecs++;
    if (!got || w !== 1 || jp !== jobv(0, 32, 32, 32, 0, 1)) begin
      errs++;
      $display("FAIL ign_job2 got %h wait %0d want %h wait 1", jp, w, jobv(0, 32, 32, 32, 0, 1));
    end
    tick();
    vecs++;
    if ({done, result_pong} !== 2'b10) begin
      errs++;
      $display("FAIL ign_done got %b want 10", {done, result_pong});
    end
    tick();
  endtask

  task automatic test_backpressure;
    int bad;
    count_in = 11'd32;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (jb.job_valid_out !== 1'b1 || cur_job() !== jobv(0, 16, 16, 16, 0, 0)) begin
        errs++;
        $display("FAIL bp_hold cyc%0d got v=%b %h want v=1 %h", i, jb.job_valid_out,
                 cur_job(), jobv(0, 16, 16, 16, 0, 0));
      end
      tick();
    end
    jb.job_ready_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (jb.job_valid_out !== 1'b0) bad++;
    end
    jb.job_ready_in = 1'b0;
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL bp_single_accept got %0d extra offers want 0", bad);
    end
    jb.job_done_in = 1'b1;
    tick();
    jb.job_done_in = 1'b0;
    vecs++;
    if ({done, jb.job_valid_out} !== 2'b00) begin
      errs++;
      $display("FAIL bp_next_pass got %b want 00", {done, jb.job_valid_out});
    end
    tick();
    vecs++;
    if ({done, result_pong} !== 2'b11) begin
      errs++;
      $display("FAIL bp_done got %b want 11", {done, result_pong});
    end
    tick();
  endtask

  task automatic test_reset_in_wait;
    bit got; int w; logic [JW-1:0] jp; logic vd;
    int seen;
    count_in = 11'd64;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    jb.job_ready_in = 1'b1;
    tick();
    jb.job_ready_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    vecs++;
    if ({jb.job_valid_out, busy, done, src_is_pong, result_pong} !== 5'b0 || cur_job() !== '0) begin
      errs++;
      $display("FAIL rst_wait_outputs got %b %h want 00000 0",
               {jb.job_valid_out, busy, done, src_is_pong, result_pong}, cur_job());
    end
    reset = 1'b0;
    jb.job_done_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      jb.job_done_in = 1'b0;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL rst_wait_aborted got %0d active cycles want 0", seen);
    end
    count_in = 11'd32;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    serve_job(got, w, jp, vd);
    vecs++;
    if (!got || w !== 0 || jp !== jobv(0, 16, 16, 16, 0, 0)) begin
      errs++;
      $display("FAIL rst_wait_job got %h wait %0d want %h wait 0", jp, w, jobv(0, 16, 16, 16, 0, 0));
    end
    tick();
    vecs++;
    if ({done, result_pong} !== 2'b11) begin
      errs++;
      $display("FAIL rst_wait_done got %b want 11", {done, result_pong});
    end
    tick();
  endtask

  initial begin
    jb.job_ready_in = 1'b0;
    jb.job_done_in  = 1'b0;
    test_reset();
    test_short();
    test_count64();
    test_count40();
    test_ignored();
    test_backpressure();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
